// File: rtl/axis_arb_pkg.sv
// Shared types and width helpers for the AXI4-Stream packet arbiter.
package axis_arb_pkg;

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} arb_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Beat counter must be able to hold MAX_BEATS itself.
  function automatic int cnt_w(input int max_beats);
    return $clog2(max_beats) + 1;
  endfunction

endpackage

// File: rtl/axis_rr_picker.sv
// Round-robin request picker: first requester at or after i_ptr, wrapping to 0.
module axis_rr_picker
  import axis_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int IDX_W       = idx_w(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] i_req,
  input  logic [IDX_W-1:0]       i_ptr,
  output logic [NUM_MASTERS-1:0] o_onehot,
  output logic [IDX_W-1:0]       o_idx,
  output logic                   o_any
);

  localparam int SW = IDX_W + 1;

  logic [SW-1:0] w_cand;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    w_cand   = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      // One spare bit so ptr+k never overflows before the wrap for non-power-of-2 counts.
      w_cand = {1'b0, i_ptr} + SW'(k);
      if (w_cand >= SW'(NUM_MASTERS)) w_cand = w_cand - SW'(NUM_MASTERS);
      if (!o_any && i_req[w_cand[IDX_W-1:0]]) begin
        o_any                       = 1'b1;
        o_idx                       = w_cand[IDX_W-1:0];
        o_onehot[w_cand[IDX_W-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_packet_arbiter.sv
// N:1 AXI4-Stream arbiter with packet-granular round-robin; the grant is held
// from the first beat until the TLAST handshake.
module axis_packet_arbiter
  import axis_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int DATA_BYTES  = 4,
  parameter int ID_W        = 8,
  parameter int DEST_W      = 4,
  parameter int USER_W      = 17,
  parameter int MAX_BEATS   = 256
) (
  input  logic                                 ACLK,
  input  logic                                 ARESET,
  input  logic [NUM_MASTERS-1:0]               s_tvalid,
  output logic [NUM_MASTERS-1:0]               s_tready,
  input  logic [NUM_MASTERS*8*DATA_BYTES-1:0]  s_tdata,
  input  logic [NUM_MASTERS*DATA_BYTES-1:0]    s_tstrb,
  input  logic [NUM_MASTERS*DATA_BYTES-1:0]    s_tkeep,
  input  logic [NUM_MASTERS-1:0]               s_tlast,
  input  logic [NUM_MASTERS*ID_W-1:0]          s_tid,
  input  logic [NUM_MASTERS*DEST_W-1:0]        s_tdest,
  input  logic [NUM_MASTERS*USER_W-1:0]        s_tuser,
  output logic                                 m_tvalid,
  output logic [8*DATA_BYTES-1:0]              m_tdata,
  output logic [DATA_BYTES-1:0]                m_tstrb,
  output logic [DATA_BYTES-1:0]                m_tkeep,
  output logic                                 m_tlast,
  output logic [ID_W-1:0]                      m_tid,
  output logic [DEST_W-1:0]                    m_tdest,
  output logic [USER_W-1:0]                    m_tuser,
  input  logic                                 m_tready,
  output logic [idx_w(NUM_MASTERS)-1:0]        grant_o,
  output logic                                 busy_o,
  output logic [cnt_w(MAX_BEATS)-1:0]          beat_cnt_o,
  output logic                                 valid_drop_o,
  output logic                                 pkt_overrun_o
);

  localparam int IDX_W = idx_w(NUM_MASTERS);
  localparam int DW    = 8 * DATA_BYTES;
  localparam int CNT_W = cnt_w(MAX_BEATS);

  arb_state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]       r_grant, r_rr_ptr, w_pick_idx;
  logic [NUM_MASTERS-1:0] r_grant_oh, w_pick_oh;
  logic                   w_pick_any;
  logic [CNT_W-1:0]       r_beat_cnt;
  logic                   r_drop_arm, r_overrun;
  logic                   w_locked, w_hs;

  logic                   w_sel_tvalid, w_sel_tlast;
  logic [DW-1:0]          w_sel_tdata;
  logic [DATA_BYTES-1:0]  w_sel_tstrb, w_sel_tkeep;
  logic [ID_W-1:0]        w_sel_tid;
  logic [DEST_W-1:0]      w_sel_tdest;
  logic [USER_W-1:0]      w_sel_tuser;

  axis_rr_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IDX_W)
  ) u_picker (
    .i_req    (s_tvalid),
    .i_ptr    (r_rr_ptr),
    .o_onehot (w_pick_oh),
    .o_idx    (w_pick_idx),
    .o_any    (w_pick_any)
  );

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_pick_any) w_state_nxt = LOCKED;
      LOCKED:  if (w_hs && w_sel_tlast) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_sel_tvalid = 1'b0;
    w_sel_tlast  = 1'b0;
    w_sel_tdata  = '0;
    w_sel_tstrb  = '0;
    w_sel_tkeep  = '0;
    w_sel_tid    = '0;
    w_sel_tdest  = '0;
    w_sel_tuser  = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (r_grant_oh[i]) begin
        w_sel_tvalid = s_tvalid[i];
        w_sel_tlast  = s_tlast[i];
        w_sel_tdata  = s_tdata[i*DW +: DW];
        w_sel_tstrb  = s_tstrb[i*DATA_BYTES +: DATA_BYTES];
        w_sel_tkeep  = s_tkeep[i*DATA_BYTES +: DATA_BYTES];
        w_sel_tid    = s_tid[i*ID_W +: ID_W];
        w_sel_tdest  = s_tdest[i*DEST_W +: DEST_W];
        w_sel_tuser  = s_tuser[i*USER_W +: USER_W];
      end
    end
  end

  // ARESET gates the datapath directly so a mid-packet reset blanks outputs at once.
  always_comb begin
    w_locked     = (r_state == LOCKED) && !ARESET;
    busy_o       = w_locked;
    m_tvalid     = w_locked && w_sel_tvalid;
    m_tlast      = w_locked && w_sel_tlast;
    m_tdata      = w_locked ? w_sel_tdata : '0;
    m_tstrb      = w_locked ? w_sel_tstrb : '0;
    m_tkeep      = w_locked ? w_sel_tkeep : '0;
    m_tid        = w_locked ? w_sel_tid   : '0;
    m_tdest      = w_locked ? w_sel_tdest : '0;
    m_tuser      = w_locked ? w_sel_tuser : '0;
    s_tready     = (w_locked && m_tready) ? r_grant_oh : '0;
    w_hs         = m_tvalid && m_tready;
    valid_drop_o = w_locked && r_drop_arm && !w_sel_tvalid;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_grant    <= '0;
      r_grant_oh <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
      r_drop_arm <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_drop_arm <= w_locked && w_sel_tvalid && !w_hs;
      r_overrun  <= w_hs && !w_sel_tlast && (r_beat_cnt == CNT_W'(MAX_BEATS - 1));
      if (r_state == IDLE && w_pick_any) begin
        r_grant    <= w_pick_idx;
        r_grant_oh <= w_pick_oh;
      end
      if (w_hs) begin
        if (w_sel_tlast) begin
          r_beat_cnt <= '0;
          r_rr_ptr   <= (r_grant == IDX_W'(NUM_MASTERS - 1)) ? '0 : r_grant + 1'b1;
        end else if (r_beat_cnt != '1) begin
          r_beat_cnt <= r_beat_cnt + 1'b1;
        end
      end
    end
  end

  assign grant_o       = r_grant;
  assign beat_cnt_o    = r_beat_cnt;
  assign pkt_overrun_o = r_overrun;

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Bench for axis_packet_arbiter: directed scenarios followed by randomized AXIS
// sources, every cycle compared with a packet-level round-robin reference.
module tb_axis_packet_arbiter;

  localparam int N    = 4;
  localparam int MAXB = 4;
  localparam int CMAX = 7;

  logic         ACLK, ARESET;
  logic [3:0]   s_tvalid, s_tready, s_tlast;
  logic [127:0] s_tdata;
  logic [15:0]  s_tstrb, s_tkeep, s_tdest;
  logic [31:0]  s_tid;
  logic [67:0]  s_tuser;
  logic         m_tvalid, m_tlast, m_tready;
  logic [31:0]  m_tdata;
  logic [3:0]   m_tstrb, m_tkeep, m_tdest;
  logic [7:0]   m_tid;
  logic [16:0]  m_tuser;
  logic [1:0]   grant_o;
  logic         busy_o, valid_drop_o, pkt_overrun_o;
  logic [2:0]   beat_cnt_o;

  axis_packet_arbiter #(
    .NUM_MASTERS(N), .DATA_BYTES(4), .ID_W(8), .DEST_W(4), .USER_W(17), .MAX_BEATS(MAXB)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tstrb(s_tstrb),
    .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tid(s_tid), .s_tdest(s_tdest), .s_tuser(s_tuser),
    .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tstrb(m_tstrb), .m_tkeep(m_tkeep),
    .m_tlast(m_tlast), .m_tid(m_tid), .m_tdest(m_tdest), .m_tuser(m_tuser),
    .m_tready(m_tready), .grant_o(grant_o), .busy_o(busy_o), .beat_cnt_o(beat_cnt_o),
    .valid_drop_o(valid_drop_o), .pkt_overrun_o(pkt_overrun_o)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Per-master source state
  logic [31:0] dat[N];
  logic [3:0]  strb[N], keep[N], dest[N];
  logic [7:0]  id[N];
  logic [16:0] user[N];
  logic [3:0]  tvv, tlv, actv;
  logic        mtr;
  int          len[N], bidx[N];

  // Reference model: owner = master holding the port (-1 when free)
  int       e_owner, e_ptr, e_last_grant, e_cnt;
  bit       e_drop_arm, e_ovf;
  logic [3:0] e_hs;

  int n_chk, n_fail;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic new_beat(input int i);
    dat[i]  = $urandom;
    strb[i] = 4'($urandom);
    keep[i] = 4'($urandom);
    id[i]   = 8'($urandom);
    dest[i] = 4'($urandom);
    user[i] = 17'($urandom);
  endtask

  function automatic int rr_winner();
    for (int k = 0; k < N; k++) begin
      int j;
      j = (e_ptr + k) % N;
      if (tvv[j]) return j;
    end
    return -1;
  endfunction

  // Drive inputs, let them settle, compare every output with the model.
  task automatic settle();
    logic        x_vld, x_last, x_busy, x_drop, x_ovf;
    logic [31:0] x_dat;
    logic [3:0]  x_strb, x_keep, x_dest, x_rdy;
    logic [7:0]  x_id;
    logic [16:0] x_user;
    int          x_grant, x_cnt;
    for (int i = 0; i < N; i++) begin
      s_tdata[i*32 +: 32] = dat[i];
      s_tstrb[i*4 +: 4]   = strb[i];
      s_tkeep[i*4 +: 4]   = keep[i];
      s_tid[i*8 +: 8]     = id[i];
      s_tdest[i*4 +: 4]   = dest[i];
      s_tuser[i*17 +: 17] = user[i];
    end
    s_tvalid = tvv;
    s_tlast  = tlv;
    m_tready = mtr;
    #2;
    x_vld = 0; x_last = 0; x_busy = 0; x_drop = 0; x_dat = 0; x_strb = 0; x_keep = 0;
    x_dest = 0; x_rdy = 0; x_id = 0; x_user = 0;
    x_grant = ARESET ? 0 : e_last_grant;
    x_cnt   = ARESET ? 0 : ((e_cnt > CMAX) ? CMAX : e_cnt);
    x_ovf   = ARESET ? 1'b0 : e_ovf;
    if (!ARESET && e_owner >= 0) begin
      x_vld  = tvv[e_owner];
      x_last = tlv[e_owner];
      x_dat  = dat[e_owner];
      x_strb = strb[e_owner];
      x_keep = keep[e_owner];
      x_id   = id[e_owner];
      x_dest = dest[e_owner];
      x_user = user[e_owner];
      x_rdy[e_owner] = mtr;
      x_busy = 1'b1;
      x_drop = e_drop_arm && !tvv[e_owner];
    end
    e_hs = x_rdy & tvv;
    chk("m_tvalid", m_tvalid, x_vld);
    chk("m_tlast", m_tlast, x_last);
    chk("m_tdata", m_tdata, x_dat);
    chk("m_tstrb", m_tstrb, x_strb);
    chk("m_tkeep", m_tkeep, x_keep);
    chk("m_tid", m_tid, x_id);
    chk("m_tdest", m_tdest, x_dest);
    chk("m_tuser", m_tuser, x_user);
    chk("s_tready", s_tready, x_rdy);
    chk("grant_o", grant_o, x_grant);
    chk("busy_o", busy_o, x_busy);
    chk("beat_cnt_o", beat_cnt_o, x_cnt);
    chk("valid_drop_o", valid_drop_o, x_drop);
    chk("pkt_overrun_o", pkt_overrun_o, x_ovf);
  endtask

  // Advance the model by one clock using the inputs in force, then step past the edge.
  task automatic tick();
    if (ARESET) begin
      e_owner = -1; e_ptr = 0; e_last_grant = 0; e_cnt = 0; e_drop_arm = 0; e_ovf = 0;
    end else if (e_owner < 0) begin
      int w;
      e_drop_arm = 0;
      e_ovf      = 0;
      w = rr_winner();
      if (w >= 0) begin
        e_owner      = w;
        e_last_grant = w;
      end
    end else begin
      bit hs;
      hs         = tvv[e_owner] && mtr;
      e_drop_arm = tvv[e_owner] && !hs;
      e_ovf      = hs && !tlv[e_owner] && (e_cnt + 1 == MAXB);
      if (hs) begin
        if (tlv[e_owner]) begin
          e_cnt   = 0;
          e_ptr   = (e_owner + 1) % N;
          e_owner = -1;
        end else begin
          e_cnt++;
        end
      end
    end
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    settle();
    chk("rst_grant", grant_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_cnt", beat_cnt_o, 0);
    chk("rst_mvalid", m_tvalid, 0);
    tick();
    ARESET = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    ARESET = 1'b0;
    tvv = '0; tlv = '0; actv = '0; mtr = 1'b0; e_hs = '0;
    e_owner = -1; e_ptr = 0; e_last_grant = 0; e_cnt = 0; e_drop_arm = 0; e_ovf = 0;
    for (int i = 0; i < N; i++) begin new_beat(i); len[i] = 0; bidx[i] = 0; end
    #1;
    do_reset();

    // Lone master 2, 3-beat packet
    tvv = 4'b0100; tlv = 4'b0000; mtr = 1'b1;
    settle(); chk("t1_idle_mvalid", m_tvalid, 0); tick();
    for (int b = 0; b < 3; b++) begin
      tlv[2] = (b == 2);
      if (b > 0) new_beat(2);
      settle();
      chk("t1_grant", grant_o, 2);
      chk("t1_tdata", m_tdata, dat[2]);
      tick();
    end
    tvv = '0; tlv = '0;
    settle(); chk("t1_busy_after", busy_o, 0); tick();

    // Everyone requesting single-beat packets
    do_reset();
    tvv = 4'b1111; tlv = 4'b1111; mtr = 1'b1;
    for (int k = 0; k < 5; k++) begin
      settle(); chk("t2_bubble", m_tvalid, 0); tick();
      settle(); chk("t2_order", grant_o, k % 4); tick();
    end

    // Master 1 owns the port while m_tready toggles
    tvv = 4'b1111; tlv = 4'b1101; mtr = 1'b1;
    settle(); tick();
    for (int k = 0; k < 4; k++) begin
      mtr = (k % 2 == 0);
      settle();
      chk("t3_tready", s_tready, mtr ? 4'b0010 : 4'b0000);
      chk("t3_tdata", m_tdata, dat[1]);
      tick();
      if (mtr) new_beat(1);
    end
    tlv[1] = 1'b1; mtr = 1'b1;
    settle(); tick();
    tvv = '0; tlv = '0;
    settle(); tick();

    // Master 0 withdraws TVALID on an unaccepted beat
    do_reset();
    tvv = 4'b0001; tlv = '0; mtr = 1'b1;
    settle(); tick();
    settle(); tick(); new_beat(0);
    settle(); tick(); new_beat(0);
    mtr = 1'b0;
    settle(); tick();
    tvv = '0;
    settle();
    chk("t4_drop", valid_drop_o, 1);
    chk("t4_grant", grant_o, 0);
    chk("t4_busy", busy_o, 1);
    tick();
    settle(); chk("t4_drop_once", valid_drop_o, 0); tick();
    tvv = 4'b0001; tlv = 4'b0001; mtr = 1'b1;
    settle(); tick();
    tvv = '0; tlv = '0;

    // 6-beat packet with MAX_BEATS=4
    tvv = 4'b0100; mtr = 1'b1;
    settle(); tick();
    for (int b = 0; b < 6; b++) begin
      tlv[2] = (b == 5);
      settle();
      if (b == 4) begin
        chk("t5_overrun", pkt_overrun_o, 1);
        chk("t5_cnt4", beat_cnt_o, 4);
      end
      if (b == 5) chk("t5_overrun_once", pkt_overrun_o, 0);
      chk("t5_grant", grant_o, 2);
      tick();
      new_beat(2);
    end
    tvv = '0; tlv = '0;
    settle(); chk("t5_cnt_after", beat_cnt_o, 0); tick();

    // Reset in the middle of master 3's packet
    tvv = 4'b1000; mtr = 1'b1;
    settle(); tick();
    settle(); tick(); new_beat(3);
    settle(); tick(); new_beat(3);
    ARESET = 1'b1;
    settle();
    chk("t6_mvalid", m_tvalid, 0);
    chk("t6_tready", s_tready, 0);
    chk("t6_mtdata", m_tdata, 0);
    chk("t6_busy", busy_o, 0);
    tick();
    ARESET = 1'b0;
    tvv = 4'b1001; tlv = 4'b1001;
    settle(); tick();
    settle(); chk("t6_first_win", grant_o, 0); tick();
    tvv = '0; tlv = '0;
    settle(); tick();

    // Randomized AXIS-compliant sources
    actv = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!actv[i] && $urandom_range(3) == 0) begin
          actv[i] = 1'b1;
          len[i]  = $urandom_range(6, 1);
          bidx[i] = 0;
          new_beat(i);
        end
        if (actv[i] && !tvv[i]) tvv[i] = ($urandom_range(3) != 0);
        tlv[i] = actv[i] && (bidx[i] == len[i] - 1);
      end
      mtr = ($urandom_range(3) != 0);
      settle();
      tick();
      for (int i = 0; i < N; i++) begin
        if (e_hs[i]) begin
          bidx[i]++;
          tvv[i] = 1'b0;
          if (bidx[i] == len[i]) actv[i] = 1'b0;
          else new_beat(i);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
